rope_field_controller: RTL and testbench

ROPE_FIELD_CONTROLLER -- requirements
Module: rope_field_controller

---
 rtl/rope_field_if.sv | 29 ++
 rtl/rope_field_controller.sv | 217 +++++++++++++++++++++
 tb/tb_rope_field_controller.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rope_field_if.sv
// rope_field_if: bundles the frame/pixel inputs and the per-rope outputs of
// rope_field_controller.
//   master : drives startOfFrame, pause, pixelX/Y, dirToggle, electroTrigger
//            and receives ropeDR, anyRopeDR, ropeRGB, ropeX, ropeLive
//   slave  : the controller side, with the directions reversed
interface rope_field_if #(
  parameter int NUM_ROPES = 6
);
  logic                        startOfFrame;
  logic                        pause;
  logic [10:0]                 pixelX;
  logic [10:0]                 pixelY;
  logic [NUM_ROPES-1:0]        dirToggle;
  logic [NUM_ROPES-1:0]        electroTrigger;
  logic [NUM_ROPES-1:0]        ropeDR;
  logic                        anyRopeDR;
  logic [7:0]                  ropeRGB;
  logic [NUM_ROPES-1:0][10:0]  ropeX;
  logic [NUM_ROPES-1:0]        ropeLive;

  modport master (
    output startOfFrame, pause, pixelX, pixelY, dirToggle, electroTrigger,
    input  ropeDR, anyRopeDR, ropeRGB, ropeX, ropeLive
  );
  modport slave (
    input  startOfFrame, pause, pixelX, pixelY, dirToggle, electroTrigger,
    output ropeDR, anyRopeDR, ropeRGB, ropeX, ropeLive
  );
endinterface

// File: rtl/rope_field_controller.sv
// rope_field_controller: NUM_ROPES vertical ropes that bounce between X_MIN
// and X_MAX, one pixel-hit detector per rope and a priority colour merge.
// Optional electro feature (SAFE->ARMED->LIVE->COOL) is built only when the
// macro ROPE_ELECTRO_EN is defined; otherwise every rope is plain 8'hB4.
// Ports:
//   clk     system clock
//   resetN  asynchronous active-low reset
//   bus     rope_field_if.slave (frame tick, pause, pixel, per-rope requests
//           in; ropeDR, anyRopeDR, ropeRGB, ropeX, ropeLive out)

// One rope: position/direction, optional electro FSM, registered hit + colour.
module rope_field_lane #(
  parameter int IDX         = 0,
  parameter int NUM_ROPES   = 6,
  parameter int X_MIN       = 32,
  parameter int X_MAX       = 600,
  parameter int ROPE_TOP    = 80,
  parameter int ROPE_LEN    = 320,
  parameter int ROPE_WIDTH  = 4,
  parameter int SPEED_STEP  = 1,
  parameter int ARM_FRAMES  = 30,
  parameter int LIVE_FRAMES = 60,
  parameter int COOL_FRAMES = 90
)(
  input  logic        clk,
  input  logic        resetN,
  input  logic        upd,
  input  logic [10:0] px,
  input  logic [10:0] py,
  input  logic        tog,
  input  logic        trig,
  output logic [10:0] x,
  output logic        dr,
  output logic [7:0]  col,
  output logic        live
);
  localparam int X_INIT = X_MIN + IDX * ((X_MAX - X_MIN) / NUM_ROPES);
  localparam logic [11:0] SPD  = 12'((IDX + 1) * SPEED_STEP);
  localparam logic [11:0] XMIN = 12'(X_MIN);
  localparam logic [11:0] XMAX = 12'(X_MAX);

  logic [11:0] xq, x_step, x_nx;
  logic        dir_q, dir_eff, dir_nx, pend_q;
  logic [7:0]  col_c;
  logic        hit;

  // A toggle coincident with the update counts, so fold it in here.
  assign dir_eff = dir_q ^ (pend_q | tog);

  always_comb begin
    if (dir_eff) x_step = xq + SPD;
    else         x_step = (xq > SPD) ? xq - SPD : 12'd0;  // no underflow wrap
    x_nx   = x_step;
    dir_nx = dir_eff;
    if (x_step >= XMAX) begin
      x_nx   = XMAX;
      dir_nx = 1'b0;
    end else if (x_step <= XMIN) begin
      x_nx   = XMIN;
      dir_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      xq     <= 12'(X_INIT);
      dir_q  <= 1'b1;
      pend_q <= 1'b0;
    end else if (upd) begin
      xq     <= x_nx;
      dir_q  <= dir_nx;
      pend_q <= 1'b0;
    end else if (tog) begin
      pend_q <= 1'b1;
    end
  end

  assign x = xq[10:0];

  assign hit = ({1'b0, px} >= xq) && ({1'b0, px} <= xq + 12'(ROPE_WIDTH - 1)) &&
               ({1'b0, py} >= 12'(ROPE_TOP)) &&
               ({1'b0, py} <= 12'(ROPE_TOP + ROPE_LEN - 1));

`ifdef ROPE_ELECTRO_EN
  typedef enum logic [1:0] {SAFE, ARMED, LIVE, COOL} st_t;
  st_t         st_q, st_nx;
  logic [15:0] cnt_q, cnt_nx;
  logic        lat_q, lat_nx;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      st_q  <= SAFE;
      cnt_q <= '0;
      lat_q <= 1'b0;
    end else begin
      st_q  <= st_nx;
      cnt_q <= cnt_nx;
      lat_q <= lat_nx;
    end
  end

  always_comb begin
    st_nx  = st_q;
    cnt_nx = cnt_q;
    lat_nx = lat_q;
    col_c  = 8'hB4;
    case (st_q)
      SAFE: begin
        if (upd && (lat_q || trig)) begin
          st_nx  = ARMED;
          cnt_nx = '0;
          lat_nx = 1'b0;
        end else if (trig) begin
          lat_nx = 1'b1;
        end
      end
      ARMED: begin
        col_c = cnt_q[2] ? 8'hB4 : 8'hFC;  // 4-frame blink, bright first
        if (upd) begin
          if (cnt_q == 16'(ARM_FRAMES - 1)) begin
            st_nx  = LIVE;
            cnt_nx = '0;
          end else cnt_nx = cnt_q + 16'd1;
        end
      end
      LIVE: begin
        col_c = 8'hFC;
        if (upd) begin
          if (cnt_q == 16'(LIVE_FRAMES - 1)) begin
            st_nx  = COOL;
            cnt_nx = '0;
          end else cnt_nx = cnt_q + 16'd1;
        end
      end
      default: begin
        col_c = 8'h92;
        if (upd) begin
          if (cnt_q == 16'(COOL_FRAMES - 1)) begin
            st_nx  = SAFE;
            cnt_nx = '0;
          end else cnt_nx = cnt_q + 16'd1;
        end
      end
    endcase
  end

  assign live = (st_q == LIVE);
`else
  logic unused_trig;
  assign unused_trig = trig;
  assign col_c = 8'hB4;
  assign live  = 1'b0;
`endif

  // Hit and colour registered together so the merge stays aligned with ropeDR.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      dr  <= 1'b0;
      col <= 8'h00;
    end else begin
      dr  <= hit;
      col <= col_c;
    end
  end
endmodule

module rope_field_controller #(
  parameter int NUM_ROPES   = 6,
  parameter int X_MIN       = 32,
  parameter int X_MAX       = 600,
  parameter int ROPE_TOP    = 80,
  parameter int ROPE_LEN    = 320,
  parameter int ROPE_WIDTH  = 4,
  parameter int SPEED_STEP  = 1,
  parameter int ARM_FRAMES  = 30,
  parameter int LIVE_FRAMES = 60,
  parameter int COOL_FRAMES = 90
)(
  input logic         clk,
  input logic         resetN,
  rope_field_if.slave bus
);
  logic                       upd;
  logic [NUM_ROPES-1:0]       dr_v, live_v;
  logic [NUM_ROPES-1:0][10:0] x_v;
  logic [NUM_ROPES-1:0][7:0]  col_v;
  logic [7:0]                 rgb;

  assign upd = bus.startOfFrame & ~bus.pause;

  for (genvar g = 0; g < NUM_ROPES; g++) begin : g_lane
    rope_field_lane #(
      .IDX(g), .NUM_ROPES(NUM_ROPES), .X_MIN(X_MIN), .X_MAX(X_MAX),
      .ROPE_TOP(ROPE_TOP), .ROPE_LEN(ROPE_LEN), .ROPE_WIDTH(ROPE_WIDTH),
      .SPEED_STEP(SPEED_STEP), .ARM_FRAMES(ARM_FRAMES),
      .LIVE_FRAMES(LIVE_FRAMES), .COOL_FRAMES(COOL_FRAMES)
    ) u_lane (
      .clk(clk), .resetN(resetN), .upd(upd),
      .px(bus.pixelX), .py(bus.pixelY),
      .tog(bus.dirToggle[g]), .trig(bus.electroTrigger[g]),
      .x(x_v[g]), .dr(dr_v[g]), .col(col_v[g]), .live(live_v[g])
    );
  end

  // Walk from the top index down so the lowest-index hit wins.
  always_comb begin
    rgb = 8'h00;
    for (int i = NUM_ROPES - 1; i >= 0; i--)
      if (dr_v[i]) rgb = col_v[i];
  end

  assign bus.ropeDR    = dr_v;
  assign bus.anyRopeDR = |dr_v;
  assign bus.ropeRGB   = rgb;
  assign bus.ropeX     = x_v;
  assign bus.ropeLive  = live_v;
endmodule

// File: tb/tb_rope_field_controller.sv
// Bench for rope_field_controller (default parameters). A frame-level model
// tracks rope position/direction and the frames elapsed since a rope was
// armed; a negedge process compares every output each cycle, and directed
// sequences add literal expectations for positions, bounces and phases.
module tb_rope_field_controller;
  localparam int NR = 6;
  localparam int XMIN = 32, XMAX = 600, TOP = 80, LEN = 320, W = 4, STEP = 1;
`ifdef ROPE_ELECTRO_EN
  localparam int ARM = 30, LIVE = 60, COOL = 90;
  localparam logic [7:0] C_ARM0 = 8'hFC;
  localparam logic       L_ON   = 1'b1;
`else
  localparam logic [7:0] C_ARM0 = 8'hB4;
  localparam logic       L_ON   = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetN = 1'b0;
  bit   started = 1'b0;
  int   checks = 0, errors = 0;
  int   fcount = 0;
  int   xo [4] = '{-1, 0, 3, 4};
  int   yo [5] = '{79, 80, 240, 399, 400};

  rope_field_if #(.NUM_ROPES(NR)) bus ();
  rope_field_controller #(.NUM_ROPES(NR)) dut (.clk(clk), .resetN(resetN), .bus(bus));

  always #5 clk = ~clk;

  // ---------------- model ----------------
  int mx [NR];
  bit mdir [NR];   // 1 = moving right
  bit mpend [NR];
  bit mlat [NR];
  int me [NR];     // frames since arming, -1 = safe
  logic [NR-1:0] edr;
  logic [7:0]    ergb;

  function automatic bit eff_dir(int i);
    return mdir[i] ^ (mpend[i] | bus.dirToggle[i]);
  endfunction
  function automatic int raw_x(int i);
    int s = (i + 1) * STEP;
    return eff_dir(i) ? mx[i] + s : mx[i] - s;
  endfunction
  function automatic int next_x(int i);
    int r = raw_x(i);
    if (r >= XMAX) return XMAX;
    if (r <= XMIN) return XMIN;
    return r;
  endfunction
  function automatic bit next_dir(int i);
    int r = raw_x(i);
    if (r >= XMAX) return 1'b0;
    if (r <= XMIN) return 1'b1;
    return eff_dir(i);
  endfunction
  function automatic logic [7:0] colour(int e);
`ifdef ROPE_ELECTRO_EN
    if (e < 0) return 8'hB4;
    if (e < ARM) return ((e / 4) % 2 == 0) ? 8'hFC : 8'hB4;
    if (e < ARM + LIVE) return 8'hFC;
    return 8'h92;
`else
    return (e < -100) ? 8'h00 : 8'hB4;
`endif
  endfunction
  function automatic logic [NR-1:0] live_vec();
    logic [NR-1:0] v = '0;
`ifdef ROPE_ELECTRO_EN
    for (int i = 0; i < NR; i++) v[i] = (me[i] >= ARM) && (me[i] < ARM + LIVE);
`endif
    return v;
  endfunction
  function automatic logic [NR-1:0] hits();
    logic [NR-1:0] h = '0;
    int px = int'(bus.pixelX);
    int py = int'(bus.pixelY);
    for (int i = 0; i < NR; i++)
      h[i] = (px >= mx[i]) && (px < mx[i] + W) && (py >= TOP) && (py < TOP + LEN);
    return h;
  endfunction
  function automatic logic [7:0] merged(logic [NR-1:0] h);
    for (int i = 0; i < NR; i++) if (h[i]) return colour(me[i]);
    return 8'h00;
  endfunction

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NR; i++) begin
        mx[i]    <= XMIN + i * ((XMAX - XMIN) / NR);
        mdir[i]  <= 1'b1;
        mpend[i] <= 1'b0;
        mlat[i]  <= 1'b0;
        me[i]    <= -1;
      end
      edr  <= '0;
      ergb <= 8'h00;
    end else begin
      edr  <= hits();
      ergb <= merged(hits());
      for (int i = 0; i < NR; i++) begin
        if (bus.startOfFrame && !bus.pause) begin
          mx[i]    <= next_x(i);
          mdir[i]  <= next_dir(i);
          mpend[i] <= 1'b0;
        end else if (bus.dirToggle[i]) begin
          mpend[i] <= 1'b1;
        end
`ifdef ROPE_ELECTRO_EN
        if (me[i] < 0) begin
          if (bus.startOfFrame && !bus.pause && (mlat[i] || bus.electroTrigger[i])) begin
            me[i]   <= 0;
            mlat[i] <= 1'b0;
          end else if (bus.electroTrigger[i]) mlat[i] <= 1'b1;
        end else if (bus.startOfFrame && !bus.pause) begin
          me[i] <= (me[i] + 1 >= ARM + LIVE + COOL) ? -1 : me[i] + 1;
        end
`endif
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started && resetN) begin
      for (int i = 0; i < NR; i++) chk($sformatf("ropeX[%0d]", i), 32'(bus.ropeX[i]), 32'(mx[i]));
      chk("ropeDR", 32'(bus.ropeDR), 32'(edr));
      chk("anyRopeDR", 32'(bus.anyRopeDR), 32'(|edr));
      chk("ropeRGB", 32'(bus.ropeRGB), 32'(ergb));
      chk("ropeLive", 32'(bus.ropeLive), 32'(live_vec()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_pulses();
    bus.startOfFrame   = 1'b0;
    bus.dirToggle      = '0;
    bus.electroTrigger = '0;
  endtask

  task automatic frame(input logic [NR-1:0] tog_at_sof);
    for (int r = 0; r < NR; r++) begin
      @(negedge clk);
      clear_pulses();
      bus.pixelX = 11'(mx[r] + xo[(r + fcount) % 4]);
      bus.pixelY = 11'(yo[(r + fcount) % 5]);
    end
    @(negedge clk);
    bus.startOfFrame = 1'b1;
    bus.dirToggle    = tog_at_sof;
    @(negedge clk);
    clear_pulses();
    fcount++;
  endtask

  task automatic frames(input int n);
    repeat (n) frame('0);
  endtask

  task automatic pulse_tog(input logic [NR-1:0] m);
    @(negedge clk); bus.dirToggle = m;
    @(negedge clk); clear_pulses();
  endtask

  task automatic pulse_trig(input logic [NR-1:0] m);
    @(negedge clk); bus.electroTrigger = m;
    @(negedge clk); clear_pulses();
  endtask

  task automatic probe(input int px, input int py);
    @(negedge clk); bus.pixelX = 11'(px); bus.pixelY = 11'(py);
    @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    int xi [NR] = '{32, 126, 220, 314, 408, 502};
    for (int i = 0; i < NR; i++) chk($sformatf("%s_ropeX[%0d]", tag, i), 32'(bus.ropeX[i]), 32'(xi[i]));
    chk({tag, "_ropeLive"}, 32'(bus.ropeLive), 32'd0);
    chk({tag, "_ropeDR"}, 32'(bus.ropeDR), 32'd0);
    chk({tag, "_anyRopeDR"}, 32'(bus.anyRopeDR), 32'd0);
    chk({tag, "_ropeRGB"}, 32'(bus.ropeRGB), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk); resetN = 1'b0;
    #1;
    if (started) reset_checks("async");
    @(posedge clk); #1;
    reset_checks("rst");
    @(negedge clk); resetN = 1'b1; started = 1'b1;
  endtask

  initial begin
    bus.startOfFrame = 1'b0; bus.pause = 1'b0;
    bus.pixelX = '0; bus.pixelY = '0;
    bus.dirToggle = '0; bus.electroTrigger = '0;

    // Motion, bounce, toggles, pause.
    do_reset();
    frames(10);
    chk("f10_rope0", 32'(bus.ropeX[0]), 32'd42);
    chk("f10_rope5", 32'(bus.ropeX[5]), 32'd562);
    frames(6);
    chk("f16_rope5", 32'(bus.ropeX[5]), 32'd598);
    frames(1);
    chk("f17_rope5_clamp", 32'(bus.ropeX[5]), 32'd600);
    frames(1);
    chk("f18_rope5_back", 32'(bus.ropeX[5]), 32'd594);
    chk("f18_rope0", 32'(bus.ropeX[0]), 32'd50);
    pulse_tog(6'b000001);
    frames(1);
    chk("tog_rope0", 32'(bus.ropeX[0]), 32'd49);
    frame(6'b000010);
    chk("tog_coincident_rope1", 32'(bus.ropeX[1]), 32'd162);
    chk("f20_rope0", 32'(bus.ropeX[0]), 32'd48);
    bus.pause = 1'b1;
    frames(1);
    chk("pause_rope0", 32'(bus.ropeX[0]), 32'd48);
    chk("pause_rope1", 32'(bus.ropeX[1]), 32'd162);
    bus.pause = 1'b0;
    frames(1);
    chk("unpause_rope0", 32'(bus.ropeX[0]), 32'd47);

    // Ropes 1 and 2 meet at x=250 with rope2 live.
    do_reset();
    pulse_trig(6'b000100);
    frames(36);
    pulse_tog(6'b000100);
    frames(26);
    chk("ovl_rope1", 32'(bus.ropeX[1]), 32'd250);
    chk("ovl_rope2", 32'(bus.ropeX[2]), 32'd250);
    probe(250, 80);
    chk("ovl_dr", 32'(bus.ropeDR), 32'h06);
    chk("ovl_rgb", 32'(bus.ropeRGB), 32'hB4);
    chk("ovl_live2", 32'(bus.ropeLive[2]), 32'(L_ON));
    probe(253, 399);
    chk("edge_dr", 32'(bus.ropeDR), 32'h06);
    probe(254, 80);
    chk("right_miss_dr", 32'(bus.ropeDR), 32'h00);
    chk("right_miss_rgb", 32'(bus.ropeRGB), 32'h00);
    probe(250, 400);
    chk("below_miss_any", 32'(bus.anyRopeDR), 32'd0);
    probe(250, 79);
    chk("above_miss_any", 32'(bus.anyRopeDR), 32'd0);

    // Reset mid-phase, then the electro phase sequence on rope2.
    do_reset();
    frames(1);
    chk("post_rst_rope2", 32'(bus.ropeX[2]), 32'd223);
    pulse_trig(6'b000100);
    frames(1);
    probe(mx[2], 80);
    chk("armed_rgb0", 32'(bus.ropeRGB), 32'(C_ARM0));
    frames(4);
    probe(mx[2], 80);
    chk("armed_rgb4", 32'(bus.ropeRGB), 32'hB4);
    frames(25);
    chk("armed_end_live", 32'(bus.ropeLive[2]), 32'd0);
    frames(1);
    chk("live_start", 32'(bus.ropeLive[2]), 32'(L_ON));
    pulse_trig(6'b000100);
    frames(59);
    chk("live_end", 32'(bus.ropeLive[2]), 32'(L_ON));
    frames(1);
    chk("cool_start", 32'(bus.ropeLive), 32'd0);
    frames(90);
    chk("safe_again", 32'(bus.ropeLive), 32'd0);
    frames(2);
    chk("no_rearm", 32'(bus.ropeLive), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
